// File: rtl/ser_load_pkg.sv
// Shared types and constants for the serial-to-parallel loader.
// SER_LOAD_PARITY_EN adds the PAR state and the even-parity check.
package ser_load_pkg;

    localparam int DATA_W      = 3;
    localparam int TIMEOUT_DEF = 15;
    localparam int TMO_W       = 8;

`ifdef SER_LOAD_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_LOAD  = 2'd3
    } state_e;

    function automatic logic even_par(input logic [DATA_W-1:0] w);
        return ^w;
    endfunction
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd3
    } state_e;
`endif

endpackage

// File: rtl/ser_load_tmo_cnt.sv
// Inter-bit idle counter; expired flags the idle cycle that makes the count reach TIMEOUT.
// Combinational expired (same cycle as inc); no backpressure.
module tmo_cnt
    import ser_load_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    assign expired = inc && (cnt_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ser_load.sv
// Serial MSB-first loader into a 3-bit register; optional parity via SER_LOAD_PARITY_EN.
// EN_OUT one cycle after the final frame bit; no backpressure, idle gaps >= TIMEOUT abort with ERR.
module ser_load
    import ser_load_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              SIN,
    input  logic              SVALID,
    output logic [DATA_W-1:0] D_OUT,
    output logic              EN_OUT,
    output logic              BUSY,
    output logic              ERR
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic              err_q, err_d;
    logic              tmo_active, tmo_clr, tmo_inc, tmo_exp;

`ifdef SER_LOAD_PARITY_EN
    assign tmo_active = (state_q == ST_SHIFT) || (state_q == ST_PAR);
`else
    assign tmo_active = (state_q == ST_SHIFT);
`endif
    assign tmo_inc = tmo_active && !SVALID;
    assign tmo_clr = !tmo_active || SVALID;

    tmo_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (tmo_clr),
        .inc     (tmo_inc),
        .expired (tmo_exp)
    );

    // D_OUT is loaded on the edge entering LOAD so it is valid while EN_OUT is high.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
        bcnt_d  = bcnt_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_SHIFT;
                    bcnt_d  = '0;
                    sh_d    = '0;
                end
            end
            ST_SHIFT: begin
                if (tmo_exp) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (SVALID) begin
                    sh_d   = DATA_W'({sh_q, SIN});
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'(DATA_W - 1)) begin
`ifdef SER_LOAD_PARITY_EN
                        state_d = ST_PAR;
`else
                        state_d = ST_LOAD;
                        dout_d  = DATA_W'({sh_q, SIN});
`endif
                    end
                end
            end
`ifdef SER_LOAD_PARITY_EN
            ST_PAR: begin
                if (tmo_exp) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (SVALID) begin
                    if (SIN == even_par(sh_q)) begin
                        state_d = ST_LOAD;
                        dout_d  = sh_q;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            ST_LOAD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            dout_q  <= '0;
            bcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            bcnt_q  <= bcnt_d;
            err_q   <= err_d;
        end
    end

    assign D_OUT  = dout_q;
    assign EN_OUT = (state_q == ST_LOAD);
    assign BUSY   = (state_q != ST_IDLE);
    assign ERR    = err_q;

endmodule

// File: tb/tb_ser_load.sv
// Randomized and directed frames against a frame-level expectation model of ser_load.
module tb_ser_load;

    localparam int T = 15;
`ifdef SER_LOAD_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       CLK, RST, START, SIN, SVALID;
    logic [2:0] D_OUT;
    logic       EN_OUT, BUSY, ERR;

    int         cyc;
    int         n_chk, n_pass;
    int         obs_en_cyc[$], exp_en_cyc[$], obs_err_cyc[$], exp_err_cyc[$];
    logic [2:0] obs_en_dat[$], exp_en_dat[$];
    logic       busy_hist[int];
    logic [2:0] last_d;

    ser_load #(.TIMEOUT(T)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .SIN    (SIN),
        .SVALID (SVALID),
        .D_OUT  (D_OUT),
        .EN_OUT (EN_OUT),
        .BUSY   (BUSY),
        .ERR    (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (EN_OUT === 1'b1) begin
            obs_en_cyc.push_back(cyc);
            obs_en_dat.push_back(D_OUT);
        end
        if (ERR === 1'b1) obs_err_cyc.push_back(cyc);
        busy_hist[cyc] = BUSY;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk = n_chk + 1;
        assert (obs === exp_v) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic drive(input logic st, input logic sv, input logic si);
        START  = st;
        SVALID = sv;
        SIN    = si;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), 1'($urandom));
    endtask

    // Expected outcome of one frame: a gap of T idle cycles aborts with ERR
    // in the cycle after the T-th idle cycle; otherwise EN one cycle after the last bit.
    task automatic run_frame(input logic [2:0] data, input logic par,
                             input int g0, input int g1, input int g2, input int g3,
                             input bit rnd_start, output int c_start, output int c_fin);
        int   g[4];
        int   nb;
        bit   aborted;
        logic b, st;
        g       = '{g0, g1, g2, g3};
        nb      = PAR_EN ? 4 : 3;
        aborted = 1'b0;
        c_start = cyc;
        drive(1'b1, 1'($urandom), 1'($urandom));
        c_fin = cyc;
        for (int i = 0; i < nb; i++) begin
            b = (i < 3) ? data[2-i] : par;
            for (int k = 0; k < g[i]; k++) begin
                st = rnd_start && !aborted && 1'($urandom);
                if (!aborted && k == T - 1) begin
                    exp_err_cyc.push_back(cyc + 1);
                    aborted = 1'b1;
                end
                drive(st, 1'b0, 1'($urandom));
            end
            c_fin = cyc;
            st    = rnd_start && !aborted && 1'($urandom);
            if (!aborted && i == nb - 1) begin
                if (PAR_EN && (par != ^data)) begin
                    exp_err_cyc.push_back(c_fin + 1);
                end else begin
                    exp_en_cyc.push_back(c_fin + 1);
                    exp_en_dat.push_back(data);
                    last_d = data;
                end
            end
            drive(st, 1'b1, b);
        end
    endtask

    task automatic settle(input string tag);
        idle(T + 3);
        chk({tag, " en_count"}, 32'(obs_en_cyc.size()), 32'(exp_en_cyc.size()));
        for (int i = 0; i < obs_en_cyc.size() && i < exp_en_cyc.size(); i++) begin
            chk($sformatf("%s en_cycle%0d", tag, i), 32'(obs_en_cyc[i]), 32'(exp_en_cyc[i]));
            chk($sformatf("%s en_data%0d", tag, i), 32'(obs_en_dat[i]), 32'(exp_en_dat[i]));
        end
        chk({tag, " err_count"}, 32'(obs_err_cyc.size()), 32'(exp_err_cyc.size()));
        for (int i = 0; i < obs_err_cyc.size() && i < exp_err_cyc.size(); i++)
            chk($sformatf("%s err_cycle%0d", tag, i), 32'(obs_err_cyc[i]), 32'(exp_err_cyc[i]));
        chk({tag, " d_hold"}, 32'(D_OUT), 32'(last_d));
        chk({tag, " busy_end"}, 32'(BUSY), 32'(0));
        obs_en_cyc.delete();
        obs_en_dat.delete();
        obs_err_cyc.delete();
        exp_en_cyc.delete();
        exp_en_dat.delete();
        exp_err_cyc.delete();
    endtask

    function automatic int pick_gap();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return T;
        if (r == 1) return T - 1;
        return $urandom_range(0, 3);
    endfunction

    initial begin
        int cs, cf, cs2, cf2;
        logic [2:0] rd;
        logic       rp;
        n_chk  = 0;
        n_pass = 0;
        last_d = 3'b000;

        // Reset held two cycles with random inputs
        RST = 1'b1; START = 1'($urandom); SVALID = 1'($urandom); SIN = 1'($urandom);
        for (int r = 0; r < 2; r++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("rst%0d d_out", r), 32'(D_OUT), 32'(0));
            chk($sformatf("rst%0d en_out", r), 32'(EN_OUT), 32'(0));
            chk($sformatf("rst%0d busy", r), 32'(BUSY), 32'(0));
            chk($sformatf("rst%0d err", r), 32'(ERR), 32'(0));
            START = 1'($urandom); SVALID = 1'($urandom); SIN = 1'($urandom);
        end
        RST = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        obs_en_cyc.delete(); obs_en_dat.delete(); obs_err_cyc.delete();

        // Contiguous 1,0,1
        run_frame(3'b101, 1'b0, 0, 0, 0, 0, 1'b0, cs, cf);
        chk("f101 busy_after_start", 32'(busy_hist[cs + 1]), 32'(1));
        chk("f101 busy_after_load", 32'(busy_hist[cf + 2]), 32'(0));
        settle("f101");

        // Gapped 0,1,1 with 5 idle cycles between bits
        run_frame(3'b011, 1'b0, 0, 5, 5, 5, 1'b0, cs, cf);
        settle("f011_gap");

        // One bit then 15 idle cycles: timeout
        run_frame(3'b100, 1'b1, 0, T, 0, 0, 1'b0, cs, cf);
        settle("timeout");

        // Gap one short of the limit still loads; limit reached before first bit aborts
        run_frame(3'b001, 1'b1, T - 1, 0, T - 1, T - 1, 1'b0, cs, cf);
        settle("gap_max");
        run_frame(3'b111, 1'b1, T, 0, 0, 0, 1'b0, cs, cf);
        settle("timeout_first");

        // Parity: 110 with wrong then correct parity bit
        run_frame(3'b110, 1'b1, 0, 0, 0, 0, 1'b0, cs, cf);
        settle("par_bad");
        run_frame(3'b110, 1'b0, 0, 0, 0, 0, 1'b0, cs, cf);
        settle("par_good");

        // Reset after the second bit, with START asserted alongside
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        RST = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        RST = 1'b0;
        last_d = 3'b000;
        chk("rst_mid busy", 32'(BUSY), 32'(0));
        chk("rst_mid d_out", 32'(D_OUT), 32'(0));
        settle("rst_mid");

        // Back-to-back 111 then 010; START during the LOAD cycle must be ignored
        run_frame(3'b111, 1'b1, 0, 2, 1, 0, 1'b1, cs, cf);
        drive(1'b1, 1'b0, 1'b0);
        run_frame(3'b010, 1'b1, 0, 0, 0, 0, 1'b0, cs2, cf2);
        chk("b2b idle_before_second", 32'(busy_hist[cf + 2]), 32'(0));
        chk("b2b busy_second", 32'(busy_hist[cs2 + 1]), 32'(1));
        settle("b2b");

        // Random frames
        for (int n = 0; n < 24; n++) begin
            rd = 3'($urandom);
            rp = ($urandom_range(0, 3) == 0) ? ~(^rd) : ^rd;
            run_frame(rd, rp, pick_gap(), pick_gap(), pick_gap(), pick_gap(),
                      1'($urandom), cs, cf);
            settle($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
